// File: rtl/pipes.sv
// Shared types for the writeback/commit stage: lane inputs, forwarding copies and commit records.
package pipes;

    typedef enum logic [1:0] {
        MSIZE_B = 2'd0,
        MSIZE_H = 2'd1,
        MSIZE_W = 2'd2,
        MSIZE_D = 2'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic        regwrite;
        logic [4:0]  wa;
        logic        memread;
        logic [63:0] result_alu;
        logic [63:0] memdata;
        msize_t      msize;
        logic        munsigned;
        logic [2:0]  addr_lo;
    } wb_lane_t;

    typedef struct packed {
        logic [4:0]  waW;
        logic [63:0] resultW;
        logic        regwriteW;
    } forward_data_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        we;
    } commit_rec_t;

endpackage

// File: rtl/wb_commit_unit_if.sv
// Memory-stage input group, register-file/forwarding outputs and commit trace handshake.
interface wb_commit_unit_if
    import pipes::*;
#(
    parameter int unsigned LANES = 2
);
    logic                        in_valid;
    logic                        in_ready;
    wb_lane_t      [LANES-1:0]   lane_i;
    logic          [LANES-1:0]   rf_we;
    logic          [LANES-1:0][4:0]  rf_wa;
    logic          [LANES-1:0][63:0] rf_wd;
    forward_data_t [LANES-1:0]   fwd_o;
    logic                        commit_valid;
    logic                        commit_ready;
    commit_rec_t                 commit_rec;

    modport master (
        output in_valid, lane_i, commit_ready,
        input  in_ready, rf_we, rf_wa, rf_wd, fwd_o, commit_valid, commit_rec
    );

    modport slave (
        input  in_valid, lane_i, commit_ready,
        output in_ready, rf_we, rf_wa, rf_wd, fwd_o, commit_valid, commit_rec
    );
endinterface

// File: rtl/wb_load_align.sv
// Combinational load extractor: shift by byte offset, truncate to access size, sign/zero extend.
module wb_load_align
    import pipes::*;
(
    input  logic [63:0] memdata_i,
    input  logic [2:0]  addr_lo_i,
    input  msize_t      msize_i,
    input  logic        munsigned_i,
    output logic [63:0] data_o
);
    logic [63:0] shifted;

    assign shifted = memdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        data_o = shifted;
        unique case (msize_i)
            MSIZE_B: data_o = {{56{~munsigned_i & shifted[7]}},  shifted[7:0]};
            MSIZE_H: data_o = {{48{~munsigned_i & shifted[15]}}, shifted[15:0]};
            MSIZE_W: data_o = {{32{~munsigned_i & shifted[31]}}, shifted[31:0]};
            MSIZE_D: data_o = shifted;
            default: data_o = shifted;
        endcase
    end
endmodule

// File: rtl/wb_commit_unit.sv
// Multi-lane writeback stage with in-order commit FIFO; the FIFO and in_ready back-pressure
// exist only when WB_COMMIT_TRACE_EN is defined.
module wb_commit_unit
    import pipes::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned DEPTH = 8
) (
    input logic             clk,
    input logic             reset,
    wb_commit_unit_if.slave bus
);
    logic                    in_ready;
    logic                    accept;
    logic [LANES-1:0][63:0]  load_data;
    logic [LANES-1:0][63:0]  wd_c;
    logic [LANES-1:0]        we_own;
    logic [LANES-1:0]        we_win;

    logic [LANES-1:0]        we_q, we_d;
    logic [LANES-1:0][4:0]   wa_q, wa_d;
    logic [LANES-1:0][63:0]  wd_q, wd_d;

    assign accept = bus.in_valid && in_ready;
    assign bus.in_ready = in_ready;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        wb_load_align u_align (
            .memdata_i   (bus.lane_i[l].memdata),
            .addr_lo_i   (bus.lane_i[l].addr_lo),
            .msize_i     (bus.lane_i[l].msize),
            .munsigned_i (bus.lane_i[l].munsigned),
            .data_o      (load_data[l])
        );

        assign wd_c[l]   = bus.lane_i[l].memread ? load_data[l] : bus.lane_i[l].result_alu;
        assign we_own[l] = bus.lane_i[l].valid && bus.lane_i[l].regwrite &&
                           (bus.lane_i[l].wa != 5'd0);

        assign bus.fwd_o[l] = forward_data_t'{waW: wa_q[l], resultW: wd_q[l], regwriteW: we_q[l]};
    end

    // Highest-numbered lane writing a register wins; older lanes to it are suppressed.
    always_comb begin
        we_win = we_own;
        for (int unsigned l = 0; l < LANES; l++) begin
            for (int unsigned k = l + 1; k < LANES; k++) begin
                if (we_own[k] && (bus.lane_i[k].wa == bus.lane_i[l].wa)) begin
                    we_win[l] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        we_d = '0;
        wa_d = wa_q;
        wd_d = wd_q;
        if (accept) begin
            we_d = we_win;
            wd_d = wd_c;
            for (int unsigned l = 0; l < LANES; l++) begin
                wa_d[l] = bus.lane_i[l].wa;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q <= '0;
            wa_q <= '0;
            wd_q <= '0;
        end else begin
            we_q <= we_d;
            wa_q <= wa_d;
            wd_q <= wd_d;
        end
    end

    assign bus.rf_we = we_q;
    assign bus.rf_wa = wa_q;
    assign bus.rf_wd = wd_q;

`ifdef WB_COMMIT_TRACE_EN
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    commit_rec_t                mem_q [DEPTH];
    commit_rec_t [DEPTH-1:0]    wr_rec;
    logic        [DEPTH-1:0]    wr_en;
    logic        [PtrW-1:0]     head_q, head_d, tail_q, tail_d;
    logic        [PtrW-1:0]     slot;
    logic        [CntW-1:0]     count_q, count_d;
    logic        [CntW-1:0]     npush;
    logic                       pop;

    assign in_ready = (count_q <= CntW'(DEPTH - LANES));
    assign pop      = (count_q != '0) && bus.commit_ready;

    // Valid lanes occupy consecutive slots from the tail in ascending lane order.
    always_comb begin
        wr_en  = '0;
        wr_rec = '0;
        slot   = tail_q;
        npush  = '0;
        if (accept) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (bus.lane_i[l].valid) begin
                    wr_en[slot]  = 1'b1;
                    wr_rec[slot] = commit_rec_t'{pc: bus.lane_i[l].pc, wa: bus.lane_i[l].wa,
                                                 wd: wd_c[l], we: we_own[l]};
                    slot  = slot + PtrW'(1);
                    npush = npush + CntW'(1);
                end
            end
        end
        tail_d  = slot;
        head_d  = head_q + PtrW'(pop);
        count_d = count_q + npush - CntW'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the head is only exposed while count is nonzero.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_q[i] <= wr_rec[i];
            end
        end
    end

    assign bus.commit_valid = (count_q != '0);
    assign bus.commit_rec   = (count_q != '0) ? mem_q[head_q] : '0;
`else
    logic [LANES-1:0] pc_par;
    logic             unused_trace;

    for (genvar l = 0; l < LANES; l++) begin : g_unused
        assign pc_par[l] = ^bus.lane_i[l].pc;
    end

    assign unused_trace     = ^{bus.commit_ready, pc_par};
    assign in_ready         = 1'b1;
    assign bus.commit_valid = 1'b0;
    assign bus.commit_rec   = '0;
`endif
endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit against a queue-based behavioural model.
module tb_wb_commit_unit;
    import pipes::*;

    localparam int unsigned LANES = 2;
    localparam int unsigned DEPTH = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    wb_commit_unit_if #(.LANES(LANES)) bus ();

    wb_commit_unit #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model state
    logic [LANES-1:0]       exp_we = '0;
    logic [LANES-1:0][4:0]  exp_wa = '0;
    logic [LANES-1:0][63:0] exp_wd = '0;
    commit_rec_t            exp_q[$];
    bit                     last_acc = 1'b0;

    function automatic logic [63:0] ref_load(logic [63:0] md, logic [2:0] lo, logic [1:0] sz,
                                             logic uns);
        logic [63:0] v, mask;
        int nbits;
        v     = md >> (int'(lo) * 8);
        nbits = 8 << int'(sz);
        mask  = (nbits == 64) ? '1 : ((64'd1 << nbits) - 64'd1);
        v     = v & mask;
        if (!uns && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit model_ready();
`ifdef WB_COMMIT_TRACE_EN
        return exp_q.size() <= int'(DEPTH - LANES);
`else
        return 1'b1;
`endif
    endfunction

    function automatic wb_lane_t mk_lane(logic v, logic [63:0] pc, logic rw, logic [4:0] wa,
                                         logic mr, logic [63:0] alu, logic [63:0] md,
                                         msize_t sz, logic uns, logic [2:0] lo);
        wb_lane_t ln;
        ln.valid = v; ln.pc = pc; ln.regwrite = rw; ln.wa = wa; ln.memread = mr;
        ln.result_alu = alu; ln.memdata = md; ln.msize = sz; ln.munsigned = uns;
        ln.addr_lo = lo;
        return ln;
    endfunction

    function automatic wb_lane_t rand_lane();
        return mk_lane(1'($urandom_range(0, 4) != 0), {32'd0, $urandom},
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                       msize_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)));
    endfunction

    // Advance the model across one rising edge, then wait for the following falling edge.
    task automatic tick();
        bit               acc, pop;
        logic [LANES-1:0] own, win;
        logic [63:0]      wd [LANES];
        wb_lane_t         ln;
        acc = bus.in_valid && model_ready();
        pop = (exp_q.size() != 0) && bus.commit_ready;
        for (int l = 0; l < LANES; l++) begin
            ln     = bus.lane_i[l];
            wd[l]  = ln.memread ? ref_load(ln.memdata, ln.addr_lo, ln.msize, ln.munsigned)
                                : ln.result_alu;
            own[l] = ln.valid && ln.regwrite && (ln.wa != 0);
        end
        for (int l = 0; l < LANES; l++) begin
            win[l] = own[l];
            for (int k = l + 1; k < LANES; k++)
                if (own[k] && bus.lane_i[k].wa == bus.lane_i[l].wa) win[l] = 1'b0;
        end
        if (acc) begin
            exp_we = win;
            for (int l = 0; l < LANES; l++) begin
                exp_wa[l] = bus.lane_i[l].wa;
                exp_wd[l] = wd[l];
            end
        end else begin
            exp_we = '0;
        end
        if (pop) void'(exp_q.pop_front());
`ifdef WB_COMMIT_TRACE_EN
        if (acc)
            for (int l = 0; l < LANES; l++)
                if (bus.lane_i[l].valid)
                    exp_q.push_back(commit_rec_t'{pc: bus.lane_i[l].pc, wa: bus.lane_i[l].wa,
                                                  wd: wd[l], we: own[l]});
`endif
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        for (int l = 0; l < LANES; l++) bus.lane_i[l] = '0;
    endtask

    task automatic drain();
        idle_inputs();
        bus.commit_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && exp_q.size() != 0; i++) tick();
        bus.commit_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.commit_ready = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        tick();
        total++; if (bus.rf_we !== '0) begin bad++; $display("FAIL reset_rf_we got=%h want=0", bus.rf_we); end
        total++; if (bus.rf_wa !== '0 || bus.rf_wd !== '0) begin bad++; $display("FAIL reset_rf_wa_wd got=%h/%h want=0", bus.rf_wa, bus.rf_wd); end
        total++; if (bus.fwd_o !== '0) begin bad++; $display("FAIL reset_fwd got=%h want=0", bus.fwd_o); end
        total++; if (bus.commit_valid !== 1'b0 || bus.commit_rec !== '0) begin bad++; $display("FAIL reset_commit got=%b/%h want=0/0", bus.commit_valid, bus.commit_rec); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        bus.commit_ready = 1'b0;
    endtask

    task automatic test_load_ext();
        drain();
        bus.commit_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.lane_i[0] = mk_lane(1, 64'h100, 1, 5'd3, 1, 64'hDEAD, 64'h80FF, MSIZE_B, 0, 3'd1);
        tick();
        total++; if (bus.rf_we[0] !== 1'b1 || bus.rf_wd[0] !== 64'hFFFF_FFFF_FFFF_FF80) begin bad++; $display("FAIL load_signed got=%b/%h want=1/ffffffffffffff80", bus.rf_we[0], bus.rf_wd[0]); end
        bus.lane_i[0].munsigned = 1'b1;
        tick();
        total++; if (bus.rf_wd[0] !== 64'h80) begin bad++; $display("FAIL load_unsigned got=%h want=80", bus.rf_wd[0]); end
        for (int i = 0; i < 24; i++) begin
            idle_inputs();
            bus.in_valid = 1'b1;
            bus.lane_i[i % LANES] = mk_lane(1, 64'(i), 1, 5'(i % LANES + 1), 1, 64'h0,
                                            {$urandom, $urandom}, msize_t'($urandom_range(0, 3)),
                                            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            tick();
            total++; if (bus.rf_we !== exp_we || bus.rf_wd[i % LANES] !== exp_wd[i % LANES]) begin bad++; $display("FAIL load_rand[%0d] got=%b/%h want=%b/%h", i, bus.rf_we, bus.rf_wd[i % LANES], exp_we, exp_wd[i % LANES]); end
        end
        idle_inputs();
    endtask

    task automatic test_conflict();
        drain();
        bus.in_valid  = 1'b1;
        bus.lane_i[0] = mk_lane(1, 64'h1000, 1, 5'd5, 0, 64'h11, 64'h0, MSIZE_D, 0, 3'd0);
        bus.lane_i[1] = mk_lane(1, 64'h1004, 1, 5'd5, 0, 64'h22, 64'h0, MSIZE_D, 0, 3'd0);
        tick();
        total++; if (bus.rf_we !== 2'b10 || bus.rf_wd[1] !== 64'h22 || bus.rf_wa[1] !== 5'd5) begin bad++; $display("FAIL conflict_rf got=%b/%h want=10/22", bus.rf_we, bus.rf_wd[1]); end
        total++; if (bus.fwd_o[0].regwriteW !== 1'b0 || bus.fwd_o[1].regwriteW !== 1'b1) begin bad++; $display("FAIL conflict_fwd got=%b%b want=10", bus.fwd_o[1].regwriteW, bus.fwd_o[0].regwriteW); end
        idle_inputs();
`ifdef WB_COMMIT_TRACE_EN
        total++; if (bus.commit_rec.pc !== 64'h1000 || bus.commit_rec.we !== 1'b1) begin bad++; $display("FAIL conflict_rec0 got=%h/%b want=1000/1", bus.commit_rec.pc, bus.commit_rec.we); end
        bus.commit_ready = 1'b1;
        tick();
        total++; if (bus.commit_rec.pc !== 64'h1004 || bus.commit_rec.wd !== 64'h22) begin bad++; $display("FAIL conflict_rec1 got=%h/%h want=1004/22", bus.commit_rec.pc, bus.commit_rec.wd); end
        bus.commit_ready = 1'b0;
`else
        tick();
`endif
        total++; if (bus.rf_we !== '0) begin bad++; $display("FAIL conflict_bubble got=%b want=00", bus.rf_we); end
    endtask

    task automatic test_x0();
        drain();
        bus.in_valid  = 1'b1;
        bus.lane_i[0] = mk_lane(1, 64'h2000, 1, 5'd0, 0, 64'h55, 64'h0, MSIZE_D, 0, 3'd0);
        tick();
        idle_inputs();
        total++; if (bus.rf_we !== '0) begin bad++; $display("FAIL x0_rf_we got=%b want=00", bus.rf_we); end
`ifdef WB_COMMIT_TRACE_EN
        total++; if (bus.commit_valid !== 1'b1 || bus.commit_rec.we !== 1'b0 || bus.commit_rec.wd !== 64'h55) begin bad++; $display("FAIL x0_rec got=%b/%b/%h want=1/0/55", bus.commit_valid, bus.commit_rec.we, bus.commit_rec.wd); end
`else
        total++; if (bus.commit_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL x0_tieoff got=%b/%b want=0/1", bus.commit_valid, bus.in_ready); end
`endif
    endtask

`ifdef WB_COMMIT_TRACE_EN
    task automatic test_fifo_full();
        drain();
        for (int g = 0; g < 4; g++) begin
            bus.in_valid = 1'b1;
            for (int l = 0; l < LANES; l++)
                bus.lane_i[l] = mk_lane(1, 64'(16 * g + 4 * l), 1, 5'(l + 1), 0,
                                        {$urandom, $urandom}, 64'h0, MSIZE_D, 0, 3'd0);
            tick();
            total++; if (bus.in_ready !== model_ready()) begin bad++; $display("FAIL full_fill_ready[%0d] got=%b want=%b", g, bus.in_ready, model_ready()); end
        end
        total++; if (bus.in_ready !== 1'b0 || bus.commit_valid !== 1'b1) begin bad++; $display("FAIL full_at_8 got=%b/%b want=0/1", bus.in_ready, bus.commit_valid); end
        repeat (2) begin
            tick();
            total++; if (bus.rf_we !== '0 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_stall got=%b/%b want=00/0", bus.rf_we, bus.in_ready); end
        end
        idle_inputs();
        bus.commit_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (bus.commit_valid !== 1'b1 || bus.commit_rec !== exp_q[0] || bus.in_ready !== model_ready()) begin bad++; $display("FAIL full_drain[%0d] got=%b/%h/%b want=1/%h/%b", i, bus.commit_valid, bus.commit_rec.pc, bus.in_ready, exp_q[0].pc, model_ready()); end
            tick();
        end
        total++; if (bus.commit_valid !== 1'b0 || bus.commit_rec !== '0) begin bad++; $display("FAIL full_empty got=%b/%h want=0/0", bus.commit_valid, bus.commit_rec); end
        bus.commit_ready = 1'b0;
    endtask

    task automatic test_push_pop_wrap();
        drain();
        for (int g = 0; g < 3; g++) begin
            bus.in_valid = 1'b1;
            for (int l = 0; l < LANES; l++)
                bus.lane_i[l] = mk_lane(1, 64'h3000 + 64'(8 * g + 4 * l), 1, 5'(l + 7), 0,
                                        {$urandom, $urandom}, 64'h0, MSIZE_D, 0, 3'd0);
            tick();
        end
        bus.commit_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            bus.in_valid  = 1'b1;
            bus.lane_i[0] = mk_lane(1, 64'h4000 + 64'(4 * i), 1, 5'd9, 0, 64'(i), 64'h0,
                                    MSIZE_D, 0, 3'd0);
            total++; if (bus.in_ready !== 1'b1 || bus.commit_rec !== exp_q[0]) begin bad++; $display("FAIL pushpop[%0d] got=%b/%h want=1/%h", i, bus.in_ready, bus.commit_rec.pc, exp_q[0].pc); end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            total++; if (bus.commit_valid !== 1'b1 || bus.commit_rec !== exp_q[0]) begin bad++; $display("FAIL pushpop_drain[%0d] got=%h want=%h", i, bus.commit_rec.pc, exp_q[0].pc); end
            tick();
        end
        bus.commit_ready = 1'b0;
    endtask
`endif

    task automatic test_random();
        bit hold;
        drain();
        for (int c = 0; c < 400; c++) begin
            hold = bus.in_valid && !last_acc;
            if (!hold) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                for (int l = 0; l < LANES; l++) bus.lane_i[l] = rand_lane();
            end
            bus.commit_ready = 1'($urandom_range(0, 2) != 0);
            tick();
            total++; if (bus.rf_we !== exp_we) begin bad++; $display("FAIL rand_we[%0d] got=%b want=%b", c, bus.rf_we, exp_we); end
            for (int l = 0; l < LANES; l++)
                if (exp_we[l]) begin
                    total++; if (bus.rf_wa[l] !== exp_wa[l] || bus.rf_wd[l] !== exp_wd[l] || bus.fwd_o[l] !== forward_data_t'{waW: exp_wa[l], resultW: exp_wd[l], regwriteW: 1'b1}) begin bad++; $display("FAIL rand_wd[%0d][%0d] got=%h/%h want=%h/%h", c, l, bus.rf_wa[l], bus.rf_wd[l], exp_wa[l], exp_wd[l]); end
                end
            total++; if (bus.in_ready !== model_ready()) begin bad++; $display("FAIL rand_ready[%0d] got=%b want=%b", c, bus.in_ready, model_ready()); end
            if (exp_q.size() != 0) begin
                total++; if (bus.commit_valid !== 1'b1 || bus.commit_rec !== exp_q[0]) begin bad++; $display("FAIL rand_rec[%0d] got=%b/%h want=1/%h", c, bus.commit_valid, bus.commit_rec, exp_q[0]); end
            end else begin
                total++; if (bus.commit_valid !== 1'b0 || bus.commit_rec !== '0) begin bad++; $display("FAIL rand_empty[%0d] got=%b/%h want=0/0", c, bus.commit_valid, bus.commit_rec); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        drain();
        for (int g = 0; g < 3; g++) begin
            bus.in_valid = 1'b1;
            for (int l = 0; l < LANES; l++)
                bus.lane_i[l] = mk_lane(1, 64'h5000 + 64'(8 * g + 4 * l), 1, 5'(l + 3), 0,
                                        64'hABC, 64'h0, MSIZE_D, 0, 3'd0);
            if (g == 2) bus.lane_i[1].valid = 1'b0;
            tick();
        end
        total++; if (bus.rf_we !== exp_we || exp_we == '0) begin bad++; $display("FAIL rst_pre_we got=%b want=%b", bus.rf_we, exp_we); end
        // Keep a valid group presented through reset; nothing may be captured.
        reset = 1'b0;
        #1;
        total++; if (bus.rf_we !== '0 || bus.commit_valid !== 1'b0) begin bad++; $display("FAIL rst_immediate got=%b/%b want=00/0", bus.rf_we, bus.commit_valid); end
        exp_q.delete();
        exp_we = '0;
        exp_wa = '0;
        exp_wd = '0;
        repeat (2) @(negedge clk);
        total++; if (bus.rf_we !== '0 || bus.commit_rec !== '0) begin bad++; $display("FAIL rst_hold got=%b/%h want=00/0", bus.rf_we, bus.commit_rec); end
        idle_inputs();
        reset = 1'b1;
        tick();
        total++; if (bus.in_ready !== 1'b1 || bus.commit_valid !== 1'b0 || bus.rf_we !== '0) begin bad++; $display("FAIL rst_release got=%b/%b/%b want=1/0/00", bus.in_ready, bus.commit_valid, bus.rf_we); end
    endtask

    initial begin
        idle_inputs();
        bus.commit_ready = 1'b0;
        test_reset();
        test_load_ext();
        test_conflict();
        test_x0();
`ifdef WB_COMMIT_TRACE_EN
        test_fifo_full();
        test_push_pop_wrap();
`endif
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
